rgb_mixer_n: RTL and testbench



---
 rtl/rgb_mixer_n.sv | 137 +++++++++++++
 tb/tb_rgb_mixer_n.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_mixer_n.sv
// rgb_mixer_n: N-channel quadrature encoder to PWM mixer with shared prescaler.
// Optional RGB_MIXER_N_LOAD_EN adds a direct per-channel level load port.
module rgb_mixer_n #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DB_COUNT = 16,
    parameter int PRESCALE = 4,
    parameter int STEP     = 1,
    parameter int SATURATE = 1,
    localparam int LCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
`ifdef RGB_MIXER_N_LOAD_EN
    input  logic                      load_valid,
    input  logic [LCW-1:0]            load_ch,
    input  logic [WIDTH-1:0]          load_value,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] level
);

    localparam int NIN = 2 * CHANNELS;
    localparam int CW  = $clog2(DB_COUNT);
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NIN-1:0]      raw;
    logic [NIN-1:0]      s1;
    logic [NIN-1:0]      s2;
    logic [NIN-1:0]      db;
    logic [CHANNELS-1:0] a_db;
    logic [CHANNELS-1:0] b_db;
    logic [PW-1:0]       pre;
    logic [WIDTH-1:0]    pwm_cnt;
    logic                tick;
    logic                boundary;

    assign raw  = {enc_b, enc_a};
    assign a_db = db[CHANNELS-1:0];
    assign b_db = db[NIN-1:CHANNELS];

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar j = 0; j < NIN; j++) begin : g_db
        logic          d;
        logic [CW-1:0] c;
        always_ff @(posedge clk) begin
            if (!reset_N) begin
                c <= '0;
                d <= 1'b0;
            end else if (s2[j] == d) begin
                c <= '0;
            end else if (c == CW'(DB_COUNT - 1)) begin
                d <= s2[j];
                c <= '0;
            end else begin
                c <= c + 1'b1;
            end
        end
        assign db[j] = d;
    end

    // One shared time base: every channel sees the same period boundary.
    assign tick     = (pre == PW'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] lvl;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] up;
        logic [WIDTH-1:0] dn;
        logic [WIDTH-1:0] shadow;
        logic             a_d;
        logic             step;
        logic             pwm;

        assign step = a_db[i] & ~a_d;

        if (SATURATE != 0) begin : g_sat
            logic [WIDTH:0] up_w;
            logic [WIDTH:0] dn_w;
            assign up_w = {1'b0, lvl} + (WIDTH + 1)'(STEP);
            assign dn_w = {1'b0, lvl} - (WIDTH + 1)'(STEP);
            assign up   = up_w[WIDTH] ? '1 : up_w[WIDTH-1:0];
            assign dn   = dn_w[WIDTH] ? '0 : dn_w[WIDTH-1:0];
        end else begin : g_wrap
            assign up = lvl + WIDTH'(STEP);
            assign dn = lvl - WIDTH'(STEP);
        end

        always_comb begin
            nxt = lvl;
            if (step) nxt = b_db[i] ? dn : up;
`ifdef RGB_MIXER_N_LOAD_EN
            if (load_valid && (load_ch == LCW'(i))) nxt = load_value;
`endif
        end

        always_ff @(posedge clk) begin
            if (!reset_N) begin
                lvl    <= '0;
                a_d    <= 1'b0;
                shadow <= '0;
                pwm    <= 1'b0;
            end else begin
                lvl <= nxt;
                a_d <= a_db[i];
                if (boundary) shadow <= lvl;
                pwm <= (shadow > pwm_cnt);
            end
        end

        assign level[i*WIDTH +: WIDTH] = lvl;
        assign pwm_out[i]              = pwm;
    end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// tb_rgb_mixer_n: two instances (saturating default, wrapping step 4) run
// against an edge-timed behavioural model plus literal spot checks.
module tb_rgb_mixer_n;

    localparam int MAXV = 255;
    localparam int P_CH  [2] = '{3, 2};
    localparam int P_DB  [2] = '{16, 2};
    localparam int P_PS  [2] = '{4, 1};
    localparam int P_ST  [2] = '{1, 4};
    localparam int P_SAT [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        reset_N = 1'b0;
    logic [2:0]  enc_a0 = '0;
    logic [2:0]  enc_b0 = '0;
    logic [2:0]  pwm0;
    logic [23:0] level0;
    logic [1:0]  enc_a1 = '0;
    logic [1:0]  enc_b1 = '0;
    logic [1:0]  pwm1;
    logic [15:0] level1;
`ifdef RGB_MIXER_N_LOAD_EN
    logic        lv0 = 1'b0;
    logic        lv1 = 1'b0;
    logic [1:0]  lc0 = '0;
    logic        lc1 = 1'b0;
    logic [7:0]  ld0 = '0;
    logic [7:0]  ld1 = '0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rgb_mixer_n #(
        .CHANNELS(3), .WIDTH(8), .DB_COUNT(16),
        .PRESCALE(4), .STEP(1), .SATURATE(1)
    ) dut0 (
        .clk(clk),
        .reset_N(reset_N),
        .enc_a(enc_a0),
        .enc_b(enc_b0),
`ifdef RGB_MIXER_N_LOAD_EN
        .load_valid(lv0),
        .load_ch(lc0),
        .load_value(ld0),
`endif
        .pwm_out(pwm0),
        .level(level0)
    );

    rgb_mixer_n #(
        .CHANNELS(2), .WIDTH(8), .DB_COUNT(2),
        .PRESCALE(1), .STEP(4), .SATURATE(0)
    ) dut1 (
        .clk(clk),
        .reset_N(reset_N),
        .enc_a(enc_a1),
        .enc_b(enc_b1),
`ifdef RGB_MIXER_N_LOAD_EN
        .load_valid(lv1),
        .load_ch(lc1),
        .load_value(ld1),
`endif
        .pwm_out(pwm1),
        .level(level1)
    );

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  k;
    bit  live = 1'b0;
    int  m_lvl [2][3];
    int  m_sh  [2][3];
    bit  m_pwm [2][3];
    bit  m_ad  [2][3];
    bit  m_db  [2][2][3];
    int  m_eq  [2][2][3];
    bit  m_r1  [2][2][3];
    bit  m_r2  [2][2][3];

    function automatic bit raw_in(int i, int ab, int c);
        if (i == 0) return (ab == 0) ? enc_a0[c] : enc_b0[c];
        return (ab == 0) ? enc_a1[c] : enc_b1[c];
    endfunction

    function automatic int ld_ch(int i);
        int r;
        r = -1;
`ifdef RGB_MIXER_N_LOAD_EN
        if (i == 0 && lv0 && lc0 < 2'd3) r = int'(lc0);
        if (i == 1 && lv1) r = int'(lc1);
`endif
        return r;
    endfunction

    function automatic int ld_val(int i);
        int r;
        r = 0;
`ifdef RGB_MIXER_N_LOAD_EN
        r = (i == 0) ? int'(ld0) : int'(ld1);
`endif
        return r;
    endfunction

    function automatic int step_lvl(int i, int v, bit dn);
        int r;
        r = dn ? v - P_ST[i] : v + P_ST[i];
        if (P_SAT[i] != 0) begin
            if (r > MAXV) r = MAXV;
            if (r < 0) r = 0;
        end else begin
            r = (r + 256) % 256;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int t;
        int cnt;
        if (!reset_N) begin
            k = 0;
            live = 1'b1;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 3; c++) begin
                    m_lvl[i][c] = 0;
                    m_sh[i][c] = 0;
                    m_pwm[i][c] = 1'b0;
                    m_ad[i][c] = 1'b0;
                    for (int ab = 0; ab < 2; ab++) begin
                        m_db[i][ab][c] = 1'b0;
                        m_eq[i][ab][c] = 0;
                        m_r1[i][ab][c] = 1'b0;
                        m_r2[i][ab][c] = 1'b0;
                    end
                end
        end else begin
            t = k;
            k++;
            for (int i = 0; i < 2; i++) begin
                cnt = (t / P_PS[i]) % 256;
                for (int c = 0; c < P_CH[i]; c++) begin
                    m_pwm[i][c] = (m_sh[i][c] > cnt);
                    if ((t % P_PS[i]) == P_PS[i] - 1 && cnt == MAXV)
                        m_sh[i][c] = m_lvl[i][c];
                    if (m_db[i][0][c] && !m_ad[i][c])
                        m_lvl[i][c] = step_lvl(i, m_lvl[i][c], m_db[i][1][c]);
                    if (ld_ch(i) == c) m_lvl[i][c] = ld_val(i);
                    m_ad[i][c] = m_db[i][0][c];
                    for (int ab = 0; ab < 2; ab++) begin
                        if (m_r2[i][ab][c] == m_db[i][ab][c]) begin
                            m_eq[i][ab][c] = k;
                        end else if (k - m_eq[i][ab][c] >= P_DB[i]) begin
                            m_db[i][ab][c] = m_r2[i][ab][c];
                            m_eq[i][ab][c] = k;
                        end
                        m_r2[i][ab][c] = m_r1[i][ab][c];
                        m_r1[i][ab][c] = raw_in(i, ab, c);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int el0;
        int el1;
        int ep0;
        int ep1;
        if (live) begin
            el0 = 0; el1 = 0; ep0 = 0; ep1 = 0;
            for (int c = 0; c < 3; c++) begin
                el0 += m_lvl[0][c] << (8 * c);
                ep0 += int'(m_pwm[0][c]) << c;
            end
            for (int c = 0; c < 2; c++) begin
                el1 += m_lvl[1][c] << (8 * c);
                ep1 += int'(m_pwm[1][c]) << c;
            end
            chk("level0", int'(level0), el0);
            chk("pwm0", int'(pwm0), ep0);
            chk("level1", int'(level1), el1);
            chk("pwm1", int'(pwm1), ep1);
        end
    end

    // ---------------- stimulus ----------------
    function automatic int lvl0(int c);
        return int'(level0[c*8 +: 8]);
    endfunction

    function automatic int lvl1(int c);
        return int'(level1[c*8 +: 8]);
    endfunction

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic det0(int c, bit b);
        enc_b0[c] = b;
        cyc(2);
        enc_a0[c] = 1'b1;
        cyc(20);
        enc_a0[c] = 1'b0;
        cyc(20);
    endtask

    task automatic det1(int c, bit b);
        enc_b1[c] = b;
        cyc(2);
        enc_a1[c] = 1'b1;
        cyc(6);
        enc_a1[c] = 1'b0;
        cyc(6);
    endtask

    initial begin
        bit any;
        int hc;
        reset_N = 1'b0;
        cyc(3);
        reset_N = 1'b1;

        any = 1'b0;
        repeat (1024) begin
            @(negedge clk);
            any |= (|pwm0) | (|level0);
        end
        chk("reset_idle", int'(any), 0);

        enc_b0[1] = 1'b0;
        cyc(2);
        enc_a0[1] = 1'b1;
        cyc(18);
        chk("latency_before", lvl0(1), 0);
        cyc(1);
        chk("latency_at", lvl0(1), 1);
        cyc(5);
        enc_a0[1] = 1'b0;
        cyc(20);
        repeat (4) det0(1, 1'b0);
        chk("ch1_up5", lvl0(1), 5);
        chk("ch0_ch2_zero", lvl0(0) + lvl0(2), 0);
        repeat (2) det0(1, 1'b1);
        chk("ch1_down2", lvl0(1), 3);

        enc_a0[0] = 1'b1;
        cyc(10);
        enc_a0[0] = 1'b0;
        cyc(30);
        chk("glitch10", lvl0(0), 0);
        enc_a0[0] = 1'b1;
        cyc(16);
        enc_a0[0] = 1'b0;
        cyc(30);
        chk("pulse16", lvl0(0), 1);

        repeat (260) det0(0, 1'b0);
        chk("sat_top", lvl0(0), 255);

        reset_N = 1'b0;
        cyc(2);
        reset_N = 1'b1;
        chk("reset_mid", int'(level0), 0);
        det0(0, 1'b1);
        chk("sat_floor", lvl0(0), 0);

        repeat (64) det0(2, 1'b0);
        chk("ch2_64", lvl0(2), 64);
        cyc(2048);
        hc = 0;
        repeat (1024) begin
            @(negedge clk);
            hc += int'(pwm0[2]);
        end
        chk("duty64", hc, 256);

        repeat (63) det1(0, 1'b0);
        chk("wrap_252", lvl1(0), 252);
        hc = 0;
        cyc(600);
        repeat (256) begin
            @(negedge clk);
            hc += int'(pwm1[0]);
        end
        chk("duty252", hc, 252);
        det1(0, 1'b0);
        chk("wrap_up0", lvl1(0), 0);
        det1(0, 1'b1);
        chk("wrap_down252", lvl1(0), 252);

        enc_b0 = '0;
        cyc(2);
        enc_a0 = 3'b111;
        cyc(20);
        enc_a0 = '0;
        cyc(20);
        chk("simul_ch0", lvl0(0), 1);
        chk("simul_ch1", lvl0(1), 1);
        chk("simul_ch2", lvl0(2), 65);

`ifdef RGB_MIXER_N_LOAD_EN
        enc_b0[2] = 1'b0;
        cyc(2);
        enc_a0[2] = 1'b1;
        cyc(18);
        lv0 = 1'b1;
        lc0 = 2'd2;
        ld0 = 8'd200;
        cyc(1);
        lv0 = 1'b0;
        chk("load_wins", lvl0(2), 200);
        enc_a0[2] = 1'b0;
        cyc(20);
        chk("load_hold", lvl0(2), 200);
        lv0 = 1'b1;
        lc0 = 2'd3;
        ld0 = 8'd7;
        cyc(1);
        lv0 = 1'b0;
        chk("load_oob", int'(level0), (200 << 16) | (1 << 8) | 1);
`endif

        repeat (6000) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(15) == 0) enc_a0[c] = ~enc_a0[c];
                if ($urandom_range(15) == 0) enc_b0[c] = ~enc_b0[c];
            end
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(3) == 0) enc_a1[c] = ~enc_a1[c];
                if ($urandom_range(3) == 0) enc_b1[c] = ~enc_b1[c];
            end
`ifdef RGB_MIXER_N_LOAD_EN
            lv0 = ($urandom_range(31) == 0);
            lc0 = 2'($urandom_range(3));
            ld0 = 8'($urandom_range(255));
            lv1 = ($urandom_range(31) == 0);
            lc1 = 1'($urandom_range(1));
            ld1 = 8'($urandom_range(255));
`endif
        end
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
